trap_status_stack: RTL and testbench

- Holds the privilege-stack fields of mstatus/sstatus: MIE/MPIE/MPP, SIE/SPIE/SPP, MPRV, SUM, MXR, TVM, TW, TSR.
- Updates them on traps, mret/sret and CSR writes.
- Sits beside the privilege-mode tracker in the privileged unit:
  - Consumes its current and next privilege mode.
  - Feeds STATUS_MPP/STATUS_SPP back to it for return targets.
  - Exports interrupt enables to the interrupt/trap logic.

---
 rtl/trap_status_stack_pkg.sv | 52 +++++
 rtl/trap_status_stack_fs_tracker.sv | 39 +++
 rtl/trap_status_stack.sv | 244 ++++++++++++++++++++++++
 tb/tb_trap_status_stack.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_status_stack_pkg.sv
// Shared definitions for the mstatus/sstatus privilege-stack block:
// core configuration struct, mstatus bit positions, sstatus read mask
// and the floating-point state encoding.
package trap_status_stack_pkg;

    // Core configuration subset consumed by the status stack.
    typedef struct packed {
        int         XLEN;
        logic       U_SUPPORTED;
        logic       S_SUPPORTED;
        logic [1:0] M_MODE;
        logic [1:0] S_MODE;
        logic [1:0] U_MODE;
    } cvw_t;

    localparam cvw_t DEFAULT_CFG = '{
        XLEN:        64,
        U_SUPPORTED: 1'b1,
        S_SUPPORTED: 1'b1,
        M_MODE:      2'b11,
        S_MODE:      2'b01,
        U_MODE:      2'b00
    };

    // mstatus bit positions
    localparam int SIE_BIT  = 1;
    localparam int MIE_BIT  = 3;
    localparam int SPIE_BIT = 5;
    localparam int MPIE_BIT = 7;
    localparam int SPP_BIT  = 8;
    localparam int MPP_LSB  = 11;
    localparam int FS_LSB   = 13;
    localparam int MPRV_BIT = 17;
    localparam int SUM_BIT  = 18;
    localparam int MXR_BIT  = 19;
    localparam int TVM_BIT  = 20;
    localparam int TW_BIT   = 21;
    localparam int TSR_BIT  = 22;

    // Low part of the sstatus view: SIE, SPIE, SPP, FS, SUM, MXR.
    // SD (bit XLEN-1) is added by the top, since its position depends on XLEN.
    localparam logic [31:0] SSTATUS_MASK_LOW = 32'h000C_6122;

    // Floating-point unit context state.
    typedef enum logic [1:0] {
        OFF     = 2'b00,
        INITIAL = 2'b01,
        CLEAN   = 2'b10,
        DIRTY   = 2'b11
    } fs_state_t;

endpackage

// File: rtl/trap_status_stack_fs_tracker.sv
// FS state machine: tracks whether floating-point context is Off, Initial,
// Clean or Dirty. Only instantiated when STATUS_FS_TRACK_EN is defined.
module status_fs_tracker
    import trap_status_stack_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       stall_i,
    input  logic       freg_write_i,
    input  logic       csr_wr_en_i,    // already qualified by stall and update priority
    input  logic [1:0] csr_wr_fs_i,
    output logic [1:0] fs_o
);

    fs_state_t state_q;
    fs_state_t state_d;

    // State register; reset puts the FPU context Off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a CSR write wins over an FP register write in the same cycle.
    always_comb begin
        state_d = state_q;
        if (csr_wr_en_i) begin
            state_d = fs_state_t'(csr_wr_fs_i);
        end else if (freg_write_i && !stall_i && (state_q != OFF)) begin
            state_d = DIRTY;
        end
    end

    assign fs_o = state_q;

endmodule

// File: rtl/trap_status_stack.sv
// mstatus/sstatus privilege-stack fields (MIE/MPIE/MPP, SIE/SPIE/SPP, MPRV,
// SUM, MXR, TVM, TW, TSR, FS). Updated on traps, mret/sret and CSR writes,
// one update per cycle with priority trap > mret > sret > mstatus > sstatus.
// Optional macro STATUS_FS_TRACK_EN enables the FS state machine; without it
// FS and SD read as zero and FRegWriteM is ignored.
module trap_status_stack
    import trap_status_stack_pkg::*;
#(
    parameter cvw_t P = DEFAULT_CFG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallW,
    input  logic               TrapM,
    input  logic               mretM,
    input  logic               sretM,
    input  logic [1:0]         PrivilegeModeW,
    input  logic [1:0]         NextPrivilegeModeM,
    input  logic               WriteMSTATUSM,
    input  logic               WriteSSTATUSM,
    input  logic [P.XLEN-1:0]  CSRWriteValM,
    input  logic               FRegWriteM,
    output logic [P.XLEN-1:0]  MSTATUS_REGW,
    output logic [P.XLEN-1:0]  SSTATUS_REGW,
    output logic               STATUS_MIE,
    output logic               STATUS_SIE,
    output logic               STATUS_MPRV,
    output logic               STATUS_SUM,
    output logic               STATUS_MXR,
    output logic               STATUS_TVM,
    output logic               STATUS_TW,
    output logic               STATUS_TSR,
    output logic [1:0]         STATUS_MPP,
    output logic               STATUS_SPP,
    output logic [1:0]         STATUS_FS
);

    localparam int XLEN = P.XLEN;
    localparam logic [XLEN-1:0] SSTATUS_MASK =
        XLEN'(SSTATUS_MASK_LOW) | (XLEN'(1) << (XLEN - 1));

    logic       mie_q,  mie_d;
    logic       mpie_q, mpie_d;
    logic [1:0] mpp_q,  mpp_d;
    logic       sie_q,  sie_d;
    logic       spie_q, spie_d;
    logic       spp_q,  spp_d;
    logic       mprv_q, mprv_d;
    logic       sum_q,  sum_d;
    logic       mxr_q,  mxr_d;
    logic       tvm_q,  tvm_d;
    logic       tw_q,   tw_d;
    logic       tsr_q,  tsr_d;

    logic [1:0] fs_cur;
    logic [1:0] wr_mpp;
    logic       wr_mpp_legal;
    logic       trap_to_s;

    assign trap_to_s = P.S_SUPPORTED && (NextPrivilegeModeM == P.S_MODE);
    assign wr_mpp    = CSRWriteValM[MPP_LSB +: 2];

    // MPP accepts only modes the core implements; 2'b10 is reserved.
    always_comb begin
        wr_mpp_legal = 1'b0;
        if (wr_mpp == P.M_MODE) begin
            wr_mpp_legal = 1'b1;
        end else if ((wr_mpp == P.S_MODE) && P.S_SUPPORTED) begin
            wr_mpp_legal = 1'b1;
        end else if ((wr_mpp == P.U_MODE) && P.U_SUPPORTED) begin
            wr_mpp_legal = 1'b1;
        end
    end

    // Next-state selection for all privilege-stack fields.
    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        mpp_d  = mpp_q;
        sie_d  = sie_q;
        spie_d = spie_q;
        spp_d  = spp_q;
        mprv_d = mprv_q;
        sum_d  = sum_q;
        mxr_d  = mxr_q;
        tvm_d  = tvm_q;
        tw_d   = tw_q;
        tsr_d  = tsr_q;

        if (!StallW) begin
            if (TrapM) begin
                if (trap_to_s) begin
                    spie_d = sie_q;
                    sie_d  = 1'b0;
                    spp_d  = PrivilegeModeW[0];
                end else begin
                    mpie_d = mie_q;
                    mie_d  = 1'b0;
                    mpp_d  = PrivilegeModeW;
                end
            end else if (mretM) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
                mpp_d  = P.U_SUPPORTED ? P.U_MODE : P.M_MODE;
                if (mpp_q != P.M_MODE) begin
                    mprv_d = 1'b0;
                end
            end else if (sretM) begin
                sie_d  = spie_q;
                spie_d = 1'b1;
                spp_d  = 1'b0;
                mprv_d = 1'b0;
            end else if (WriteMSTATUSM) begin
                sie_d  = CSRWriteValM[SIE_BIT];
                mie_d  = CSRWriteValM[MIE_BIT];
                spie_d = CSRWriteValM[SPIE_BIT];
                mpie_d = CSRWriteValM[MPIE_BIT];
                spp_d  = CSRWriteValM[SPP_BIT];
                if (wr_mpp_legal) begin
                    mpp_d = wr_mpp;
                end
                mprv_d = CSRWriteValM[MPRV_BIT];
                sum_d  = CSRWriteValM[SUM_BIT];
                mxr_d  = CSRWriteValM[MXR_BIT];
                tvm_d  = CSRWriteValM[TVM_BIT];
                tw_d   = CSRWriteValM[TW_BIT];
                tsr_d  = CSRWriteValM[TSR_BIT];
            end else if (WriteSSTATUSM) begin
                sie_d  = CSRWriteValM[SIE_BIT];
                spie_d = CSRWriteValM[SPIE_BIT];
                spp_d  = CSRWriteValM[SPP_BIT];
                sum_d  = CSRWriteValM[SUM_BIT];
                mxr_d  = CSRWriteValM[MXR_BIT];
            end
        end

        // Fields of unimplemented privilege levels are hardwired.
        if (!P.S_SUPPORTED) begin
            sie_d  = 1'b0;
            spie_d = 1'b0;
            spp_d  = 1'b0;
            sum_d  = 1'b0;
            mxr_d  = 1'b0;
            tvm_d  = 1'b0;
            tsr_d  = 1'b0;
        end
        if (!P.U_SUPPORTED) begin
            mprv_d = 1'b0;
            tw_d   = 1'b0;
            mpp_d  = P.M_MODE;
        end
    end

    // Field registers; MPP resets to machine mode, everything else to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
            mpp_q  <= P.M_MODE;
            sie_q  <= 1'b0;
            spie_q <= 1'b0;
            spp_q  <= 1'b0;
            mprv_q <= 1'b0;
            sum_q  <= 1'b0;
            mxr_q  <= 1'b0;
            tvm_q  <= 1'b0;
            tw_q   <= 1'b0;
            tsr_q  <= 1'b0;
        end else begin
            mie_q  <= mie_d;
            mpie_q <= mpie_d;
            mpp_q  <= mpp_d;
            sie_q  <= sie_d;
            spie_q <= spie_d;
            spp_q  <= spp_d;
            mprv_q <= mprv_d;
            sum_q  <= sum_d;
            mxr_q  <= mxr_d;
            tvm_q  <= tvm_d;
            tw_q   <= tw_d;
            tsr_q  <= tsr_d;
        end
    end

    // Only part of the write data maps onto implemented fields.
    logic unused_csr_wdata;
    assign unused_csr_wdata = ^CSRWriteValM;

`ifdef STATUS_FS_TRACK_EN
    logic fs_csr_wr_en;

    // FS is written only when a CSR write is the winning update this cycle.
    assign fs_csr_wr_en = !StallW && !TrapM && !mretM && !sretM &&
                          (WriteMSTATUSM || WriteSSTATUSM);

    status_fs_tracker u_fs_tracker (
        .clk_i        (clk),
        .rst_ni       (reset),
        .stall_i      (StallW),
        .freg_write_i (FRegWriteM),
        .csr_wr_en_i  (fs_csr_wr_en),
        .csr_wr_fs_i  (CSRWriteValM[FS_LSB +: 2]),
        .fs_o         (fs_cur)
    );
`else
    logic unused_fregwrite;
    assign unused_fregwrite = FRegWriteM;
    assign fs_cur = 2'b00;
`endif

    // Assemble the architectural read views from the field registers.
    always_comb begin
        MSTATUS_REGW              = '0;
        MSTATUS_REGW[SIE_BIT]     = sie_q;
        MSTATUS_REGW[MIE_BIT]     = mie_q;
        MSTATUS_REGW[SPIE_BIT]    = spie_q;
        MSTATUS_REGW[MPIE_BIT]    = mpie_q;
        MSTATUS_REGW[SPP_BIT]     = spp_q;
        MSTATUS_REGW[MPP_LSB +: 2] = mpp_q;
        MSTATUS_REGW[FS_LSB +: 2] = fs_cur;
        MSTATUS_REGW[MPRV_BIT]    = mprv_q;
        MSTATUS_REGW[SUM_BIT]     = sum_q;
        MSTATUS_REGW[MXR_BIT]     = mxr_q;
        MSTATUS_REGW[TVM_BIT]     = tvm_q;
        MSTATUS_REGW[TW_BIT]      = tw_q;
        MSTATUS_REGW[TSR_BIT]     = tsr_q;
        MSTATUS_REGW[XLEN-1]      = (fs_cur == 2'b11);
    end

    assign SSTATUS_REGW = MSTATUS_REGW & SSTATUS_MASK;

    assign STATUS_MIE  = mie_q;
    assign STATUS_SIE  = sie_q;
    assign STATUS_MPRV = mprv_q;
    assign STATUS_SUM  = sum_q;
    assign STATUS_MXR  = mxr_q;
    assign STATUS_TVM  = tvm_q;
    assign STATUS_TW   = tw_q;
    assign STATUS_TSR  = tsr_q;
    assign STATUS_MPP  = mpp_q;
    assign STATUS_SPP  = spp_q;
    assign STATUS_FS   = fs_cur;

endmodule

// File: tb/tb_trap_status_stack.sv
// Directed scoreboard bench for trap_status_stack (XLEN=64, S and U present).
module tb_trap_status_stack;
    import trap_status_stack_pkg::*;

    localparam cvw_t CFG = DEFAULT_CFG;
    localparam logic [63:0] SMASK = 64'h8000_0000_000C_6122;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallW, TrapM, mretM, sretM;
    logic [1:0]  PrivilegeModeW, NextPrivilegeModeM;
    logic        WriteMSTATUSM, WriteSSTATUSM, FRegWriteM;
    logic [63:0] CSRWriteValM;
    logic [63:0] MSTATUS_REGW, SSTATUS_REGW;
    logic        STATUS_MIE, STATUS_SIE, STATUS_MPRV, STATUS_SUM, STATUS_MXR;
    logic        STATUS_TVM, STATUS_TW, STATUS_TSR, STATUS_SPP;
    logic [1:0]  STATUS_MPP, STATUS_FS;

    trap_status_stack #(.P(CFG)) dut (
        .clk                (clk),
        .reset              (reset),
        .StallW             (StallW),
        .TrapM              (TrapM),
        .mretM              (mretM),
        .sretM              (sretM),
        .PrivilegeModeW     (PrivilegeModeW),
        .NextPrivilegeModeM (NextPrivilegeModeM),
        .WriteMSTATUSM      (WriteMSTATUSM),
        .WriteSSTATUSM      (WriteSSTATUSM),
        .CSRWriteValM       (CSRWriteValM),
        .FRegWriteM         (FRegWriteM),
        .MSTATUS_REGW       (MSTATUS_REGW),
        .SSTATUS_REGW       (SSTATUS_REGW),
        .STATUS_MIE         (STATUS_MIE),
        .STATUS_SIE         (STATUS_SIE),
        .STATUS_MPRV        (STATUS_MPRV),
        .STATUS_SUM         (STATUS_SUM),
        .STATUS_MXR         (STATUS_MXR),
        .STATUS_TVM         (STATUS_TVM),
        .STATUS_TW          (STATUS_TW),
        .STATUS_TSR         (STATUS_TSR),
        .STATUS_MPP         (STATUS_MPP),
        .STATUS_SPP         (STATUS_SPP),
        .STATUS_FS          (STATUS_FS)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] mstatus;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic compare_one(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [63:0] m);
        exp_t e;
        e.tag = tag;
        e.mstatus = m;
        sb_q.push_back(e);
    endtask

    // Pop one expectation and compare it to the DUT's current outputs.
    task automatic check_front();
        exp_t        e;
        logic [12:0] fields_got;
        logic [12:0] fields_exp;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            fields_got = {STATUS_TSR, STATUS_TW, STATUS_TVM, STATUS_MXR, STATUS_SUM,
                          STATUS_MPRV, STATUS_FS, STATUS_MPP, STATUS_SPP, STATUS_MIE, STATUS_SIE};
            fields_exp = {e.mstatus[22], e.mstatus[21], e.mstatus[20], e.mstatus[19],
                          e.mstatus[18], e.mstatus[17], e.mstatus[14:13], e.mstatus[12:11],
                          e.mstatus[8], e.mstatus[3], e.mstatus[1]};
            compare_one({e.tag, "_mstatus"}, MSTATUS_REGW, e.mstatus);
            compare_one({e.tag, "_sstatus"}, SSTATUS_REGW, e.mstatus & SMASK);
            compare_one({e.tag, "_fields"}, 64'(fields_got), 64'(fields_exp));
            $display("step %-18s mstatus=%h sstatus=%h", e.tag, MSTATUS_REGW, SSTATUS_REGW);
        end
    endtask

    task automatic idle_inputs();
        StallW             = 1'b0;
        TrapM              = 1'b0;
        mretM              = 1'b0;
        sretM              = 1'b0;
        PrivilegeModeW     = 2'b11;
        NextPrivilegeModeM = 2'b11;
        WriteMSTATUSM      = 1'b0;
        WriteSSTATUSM      = 1'b0;
        CSRWriteValM       = 64'h0;
        FRegWriteM         = 1'b0;
    endtask

    // Apply the currently driven inputs for one clock, then check.
    task automatic tick(input string tag, input logic [63:0] m);
        expect_state(tag, m);
        @(posedge clk);
        #1;
        check_front();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        expect_state("reset", 64'h1800);
        check_front();
        @(negedge clk);
        reset = 1'b1;
        tick("idle", 64'h1800);

        // Machine trap from U, then mret
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1808;
        tick("set_mie", 64'h1808);
        TrapM = 1'b1; PrivilegeModeW = 2'b00; NextPrivilegeModeM = 2'b11;
        tick("trap_u_to_m", 64'h0080);
        mretM = 1'b1;
        tick("mret", 64'h0088);

        // Supervisor trap from S, then sret (clears MPRV)
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h21802;
        tick("set_sie_mprv", 64'h21802);
        TrapM = 1'b1; PrivilegeModeW = 2'b01; NextPrivilegeModeM = 2'b01;
        tick("trap_s_to_s", 64'h21920);
        sretM = 1'b1;
        tick("sret", 64'h1822);

        // Reserved MPP encoding is rejected
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1000;
        tick("mpp_reserved", 64'h1800);

        // mret with old MPP=M keeps MPRV
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h21888;
        tick("set_mprv_mppm", 64'h21888);
        mretM = 1'b1;
        tick("mret_keep_mprv", 64'h20088);

        // sstatus writes touch only supervisor-visible fields
        WriteSSTATUSM = 1'b1; CSRWriteValM = 64'hC0122;
        tick("sstatus_set", 64'hE01AA);
        WriteSSTATUSM = 1'b1; CSRWriteValM = 64'h88;
        tick("sstatus_0x88", 64'h20088);

        // Trap beats a simultaneous mstatus write
        TrapM = 1'b1; PrivilegeModeW = 2'b11; NextPrivilegeModeM = 2'b11;
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'hFFFF;
        tick("trap_vs_write", 64'h21880);

        // Stall freezes everything
        StallW = 1'b1; mretM = 1'b1;
        tick("stall_mret", 64'h21880);
        StallW = 1'b1; WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h0;
        tick("stall_write", 64'h21880);

        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h800;
        tick("mpp_s", 64'h0800);
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h701800;
        tick("tvm_tw_tsr", 64'h701800);

        // Asynchronous reset between edges with a write pending
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h0;
        #2;
        reset = 1'b0;
        #1;
        expect_state("async_reset", 64'h1800);
        check_front();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick("after_reset", 64'h1800);

`ifdef STATUS_FS_TRACK_EN
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h3800;
        tick("fs_initial", 64'h3800);
        StallW = 1'b1; FRegWriteM = 1'b1;
        tick("fs_stall", 64'h3800);
        FRegWriteM = 1'b1;
        tick("fs_dirty", 64'h8000_0000_0000_7800);
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1800; FRegWriteM = 1'b1;
        tick("fs_csr_wins", 64'h1800);
        FRegWriteM = 1'b1;
        tick("fs_off_hold", 64'h1800);
`else
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h7800;
        tick("fs_ignored", 64'h1800);
        FRegWriteM = 1'b1;
        tick("fs_freg_ignored", 64'h1800);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
